// File: rtl/secure_boot_chain.sv
// secure_boot_chain
// Multi-stage chain-of-trust boot controller. On a rising edge of power_on it
// fetches NUM_STAGES images of IMG_WORDS words each, folds every word into a
// rotate-XOR digest and checks it against that stage's golden digest. A
// mismatching stage is re-read up to MAX_RETRIES extra times; the boot ends in
// boot_ok, or in a boot_fail lockout that only rst_n clears.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   power_on          boot request level; a boot starts on its rising edge
//   golden_digest     stage k digest at [k*WORD_W +: WORD_W]
//   mem_req/mem_addr  image read request, address = stage*IMG_WORDS + word
//   mem_valid/mem_data read data qualifier and image word
//   busy              fetching or checking
//   stage_idx         current stage
//   stage_pass        one-cycle pulse per verified stage
//   retry_cnt         retries used in the current stage
//   boot_ok/boot_fail final verdicts; fail_stage = stage that locked out
// All outputs are registered and cleared by reset.
module secure_boot_chain #(
  parameter int NUM_STAGES  = 4,
  parameter int IMG_WORDS   = 16,
  parameter int WORD_W      = 32,
  parameter int MAX_RETRIES = 2,
  parameter logic [WORD_W-1:0] SEED = '0,
  parameter int ADDR_W      = $clog2(NUM_STAGES*IMG_WORDS),
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES+1) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         power_on,
  input  logic [NUM_STAGES*WORD_W-1:0] golden_digest,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_valid,
  input  logic [WORD_W-1:0]            mem_data,
  output logic                         busy,
  output logic [SW-1:0]                stage_idx,
  output logic                         stage_pass,
  output logic [RW-1:0]                retry_cnt,
  output logic                         boot_ok,
  output logic                         boot_fail,
  output logic [SW-1:0]                fail_stage
);

  localparam int WW = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_DONE, S_FAIL} state_t;

  // Per-attempt context carried between cycles.
  typedef struct packed {
    logic [SW-1:0]     stage;
    logic [WW-1:0]     word;
    logic [WORD_W-1:0] acc;
  } ctx_t;

  state_t        state_q, state_n;
  ctx_t          ctx_q, ctx_n;
  logic [RW-1:0] retry_n;
  logic [SW-1:0] fstage_n;
  logic          pass_n;
  logic          pwr_q;
  logic          rise, fall;
  logic [WORD_W-1:0] gold;
  logic [31:0]   addr_n;

  assign rise = power_on & ~pwr_q;
  assign fall = ~power_on & pwr_q;
  assign gold = golden_digest[int'(ctx_q.stage)*WORD_W +: WORD_W];
  // Address is built from the next-state context so that it is registered
  // alongside the word counter and stays put while mem_valid is low.
  assign addr_n = 32'(ctx_n.stage) * 32'(IMG_WORDS) + 32'(ctx_n.word);

  always_comb begin
    state_n  = state_q;
    ctx_n    = ctx_q;
    retry_n  = retry_cnt;
    fstage_n = fail_stage;
    pass_n   = 1'b0;
    case (state_q)
      S_IDLE: if (rise) begin
        state_n = S_FETCH;
        ctx_n   = '{stage: '0, word: '0, acc: SEED};
        retry_n = '0;
      end
      S_FETCH: begin
        if (!power_on) state_n = S_IDLE;
        else if (mem_valid) begin
          ctx_n.acc = {ctx_q.acc[WORD_W-2:0], ctx_q.acc[WORD_W-1]} ^ mem_data;
          if (ctx_q.word == WW'(IMG_WORDS-1)) begin
            ctx_n.word = '0;
            state_n    = S_CHECK;
          end else begin
            ctx_n.word = ctx_q.word + 1'b1;
          end
        end
      end
      S_CHECK: begin
        // Abort wins over the digest verdict on the same edge.
        if (!power_on) state_n = S_IDLE;
        else if (ctx_q.acc == gold) begin
          pass_n  = 1'b1;
          retry_n = '0;
          if (ctx_q.stage == SW'(NUM_STAGES-1)) state_n = S_DONE;
          else begin
            state_n = S_FETCH;
            ctx_n   = '{stage: ctx_q.stage + 1'b1, word: '0, acc: SEED};
          end
        end else if (retry_cnt < RW'(MAX_RETRIES)) begin
          retry_n = retry_cnt + 1'b1;
          state_n = S_FETCH;
          ctx_n   = '{stage: ctx_q.stage, word: '0, acc: SEED};
        end else begin
          fstage_n = ctx_q.stage;
          state_n  = S_FAIL;
        end
      end
      S_DONE: if (fall) state_n = S_IDLE;
      S_FAIL: state_n = S_FAIL;  // lockout: only reset leaves
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ctx_q      <= '0;
      // Held high in reset so a power_on already asserted at release is
      // not mistaken for a rising edge.
      pwr_q      <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      stage_idx  <= '0;
      stage_pass <= 1'b0;
      retry_cnt  <= '0;
      boot_ok    <= 1'b0;
      boot_fail  <= 1'b0;
      fail_stage <= '0;
    end else begin
      state_q    <= state_n;
      ctx_q      <= ctx_n;
      pwr_q      <= power_on;
      mem_req    <= (state_n == S_FETCH);
      mem_addr   <= addr_n[ADDR_W-1:0];
      busy       <= (state_n == S_FETCH) || (state_n == S_CHECK);
      stage_idx  <= ctx_n.stage;
      stage_pass <= pass_n;
      retry_cnt  <= retry_n;
      boot_ok    <= (state_n == S_DONE);
      boot_fail  <= (state_n == S_FAIL);
      fail_stage <= fstage_n;
    end
  end

endmodule

// File: tb/tb_secure_boot_chain.sv
module tb_secure_boot_chain;
  localparam int NS = 2, IW = 4, W = 8, MR = 1, AW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            power_on = 1'b0;
  logic            mem_valid = 1'b1;
  logic [NS*W-1:0] golden = {8'h02, 8'h02};
  logic [W-1:0]    mem_data;
  logic            mem_req, busy, stage_pass, boot_ok, boot_fail;
  logic [AW-1:0]   mem_addr;
  logic [0:0]      stage_idx, retry_cnt, fail_stage;
  logic [10:0]     outs;

  int tests = 0, fails = 0;
  int req_q[$];
  int hits7 = 0;
  int bad_base = 0;
  bit bad_arm = 1'b0;
  logic [W-1:0] img [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};

  secure_boot_chain #(.NUM_STAGES(NS), .IMG_WORDS(IW), .WORD_W(W),
                      .MAX_RETRIES(MR), .SEED(8'h00), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .power_on(power_on), .golden_digest(golden),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_data(mem_data), .busy(busy), .stage_idx(stage_idx),
    .stage_pass(stage_pass), .retry_cnt(retry_cnt), .boot_ok(boot_ok),
    .boot_fail(boot_fail), .fail_stage(fail_stage));

  always #5 clk = ~clk;

  // Image memory; when armed, the first read of address 7 returns a corrupt word.
  always @(posedge clk) if (mem_req && mem_valid && mem_addr == 3'd7) hits7 <= hits7 + 1;
  assign mem_data = (bad_arm && mem_addr == 3'd7 && hits7 == bad_base) ? 8'h05 : img[mem_addr];
  assign outs = {mem_req, mem_addr, busy, stage_idx, stage_pass, retry_cnt,
                 boot_ok, boot_fail, fail_stage};

  // Starts a boot from IDLE (call at a negedge) and records every address
  // presented with mem_req. end_k = cycles after E0 until boot_ok/boot_fail.
  task automatic run_boot(input bit stall, output int end_k, output int npass,
                          output bit saw_fail, output int retry_max, output int retry_end);
    bit ph = 1'b0;
    end_k = -1; npass = 0; saw_fail = 0; retry_max = 0; retry_end = -1;
    req_q.delete();
    power_on = 1'b1; mem_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (stage_pass) npass++;
      if (int'(retry_cnt) > retry_max) retry_max = int'(retry_cnt);
      if (boot_ok || boot_fail) begin
        saw_fail = boot_fail; end_k = k; retry_end = int'(retry_cnt); break;
      end
      if (mem_req) begin
        req_q.push_back(int'(mem_addr));
        if (stall) begin mem_valid = ph; ph = ~ph; end
      end else mem_valid = 1'b1;
    end
    mem_valid = 1'b1;
  endtask

  task automatic go_idle();
    power_on = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    tests++; if (outs !== '0) begin fails++; $display("FAIL reset_outs got=%b want=0", outs); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle busy=%b want=0", busy); end
  endtask

  task automatic test_clean();
    int ek, np, rm, re; bit sf;
    run_boot(1'b0, ek, np, sf, rm, re);
    tests++; if (ek != 10) begin fails++; $display("FAIL clean_latency got=%0d want=10", ek); end
    tests++; if (np != 2) begin fails++; $display("FAIL clean_pass_cnt got=%0d want=2", np); end
    tests++; if (sf) begin fails++; $display("FAIL clean_no_fail got=%0d want=0", sf); end
    tests++; if (req_q.size() != 8) begin fails++; $display("FAIL clean_addr_cnt got=%0d want=8", req_q.size()); end
    else foreach (req_q[i]) begin
      tests++; if (req_q[i] != i) begin fails++; $display("FAIL clean_addr[%0d] got=%0d want=%0d", i, req_q[i], i); end
    end
    tests++; if (busy !== 1'b0 || stage_idx !== 1'b1) begin
      fails++; $display("FAIL clean_done busy=%b stage=%b want 0/1", busy, stage_idx); end
    go_idle();
    tests++; if (boot_ok !== 1'b0) begin fails++; $display("FAIL clean_clear_ok got=%b want=0", boot_ok); end
  endtask

  task automatic test_stall();
    int ek, np, rm, re; bit sf;
    run_boot(1'b1, ek, np, sf, rm, re);
    tests++; if (ek != 18) begin fails++; $display("FAIL stall_latency got=%0d want=18", ek); end
    tests++; if (np != 2) begin fails++; $display("FAIL stall_pass_cnt got=%0d want=2", np); end
    tests++; if (req_q.size() != 16) begin fails++; $display("FAIL stall_addr_cnt got=%0d want=16", req_q.size()); end
    else foreach (req_q[i]) begin
      tests++; if (req_q[i] != i/2) begin fails++; $display("FAIL stall_addr[%0d] got=%0d want=%0d", i, req_q[i], i/2); end
    end
    go_idle();
  endtask

  task automatic test_retry();
    int ek, np, rm, re; bit sf;
    int exp_a[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
    bad_base = hits7; bad_arm = 1'b1;
    run_boot(1'b0, ek, np, sf, rm, re);
    bad_arm = 1'b0;
    tests++; if (ek != 15) begin fails++; $display("FAIL retry_latency got=%0d want=15", ek); end
    tests++; if (rm != 1) begin fails++; $display("FAIL retry_max got=%0d want=1", rm); end
    tests++; if (re != 0) begin fails++; $display("FAIL retry_at_ok got=%0d want=0", re); end
    tests++; if (np != 2 || sf) begin fails++; $display("FAIL retry_pass got=%0d/%0d want=2/0", np, sf); end
    tests++; if (req_q.size() != 12) begin fails++; $display("FAIL retry_addr_cnt got=%0d want=12", req_q.size()); end
    else foreach (req_q[i]) begin
      tests++; if (req_q[i] != exp_a[i]) begin fails++; $display("FAIL retry_addr[%0d] got=%0d want=%0d", i, req_q[i], exp_a[i]); end
    end
    go_idle();
  endtask

  task automatic test_abort();
    bit hit = 1'b0, saw_ok = 1'b0, ok_again = 1'b0;
    power_on = 1'b1;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 3'd6) begin hit = 1'b1; power_on = 1'b0; end
    end
    tests++; if (!hit) begin fails++; $display("FAIL abort_reach_addr6 got=0 want=1"); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || mem_req !== 1'b0 || stage_pass !== 1'b0 || boot_ok !== 1'b0) begin
      fails++; $display("FAIL abort_idle busy=%b req=%b pass=%b ok=%b want 0000", busy, mem_req, stage_pass, boot_ok); end
    repeat (3) begin @(negedge clk); if (boot_ok) saw_ok = 1'b1; end
    tests++; if (saw_ok) begin fails++; $display("FAIL abort_no_ok got=1 want=0"); end
    power_on = 1'b1;
    @(negedge clk);
    tests++; if (mem_req !== 1'b1 || mem_addr !== 3'd0 || stage_idx !== 1'b0) begin
      fails++; $display("FAIL abort_restart req=%b addr=%0d stage=%b want 1/0/0", mem_req, mem_addr, stage_idx); end
    for (int k = 0; k < 30 && !ok_again; k++) begin @(negedge clk); ok_again = boot_ok; end
    tests++; if (!ok_again) begin fails++; $display("FAIL abort_reboot_ok got=0 want=1"); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    bit woke = 1'b0;
    power_on = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (mem_req !== 1'b1 || mem_addr !== 3'd2) begin
      fails++; $display("FAIL rstmid_fetch req=%b addr=%0d want 1/2", mem_req, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (outs !== '0) begin fails++; $display("FAIL rstmid_async got=%b want=0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (busy || mem_req) woke = 1'b1; end
    tests++; if (woke) begin fails++; $display("FAIL rstmid_no_boot got=1 want=0"); end
    go_idle();
  endtask

  task automatic test_lockout();
    int ek, np, rm, re; bit sf;
    golden = {8'h02, 8'hFF};
    run_boot(1'b0, ek, np, sf, rm, re);
    tests++; if (!sf || ek != 10) begin fails++; $display("FAIL lock_fail got=%0d@%0d want=1@10", sf, ek); end
    tests++; if (req_q.size() != 8 || np != 0) begin
      fails++; $display("FAIL lock_attempts addrs=%0d pass=%0d want 8/0", req_q.size(), np); end
    tests++; if (fail_stage !== 1'b0 || boot_ok !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL lock_state stage=%b ok=%b busy=%b want 0/0/0", fail_stage, boot_ok, busy); end
    repeat (3) begin power_on = 1'b0; @(negedge clk); power_on = 1'b1; @(negedge clk); end
    tests++; if (boot_fail !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL lock_sticky fail=%b req=%b busy=%b want 1/0/0", boot_fail, mem_req, busy); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (outs !== '0) begin fails++; $display("FAIL lock_reset got=%b want=0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    golden = {8'h02, 8'h02};
    go_idle();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stall();
    test_retry();
    test_abort();
    test_reset_mid();
    test_lockout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
